ntps_mdio_arbiter: RTL
======================

Name: ntps_mdio_arbiter

Overview:
Shares the single board MDIO management bus between NUM_REQ independent requesters, such as the per-network-path MAC/PHY managers and the host-side MDIO controller. It arbitrates round-robin and runs one Clause-22 MDIO frame per grant. It generates MDC and drives or releases MDIO, and returns read data or error status to the granted requester. It sits between the network paths and the board phy_mdc/phy_mdio pins, and replaces the passive merge of per-path mdio outputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MDC_DIV, 25, axi_aclk cycles per MDC half-period (>=2); 125 MHz gives 2.5 MHz MDC
PREAMBLE_LEN, 32, number of preamble '1' bits (fixed by IEEE 802.3 Clause 22)

Ports:
axi_aclk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester transaction request
req_ready  out  NUM_REQ  one-cycle accept pulse; payload latched in that cycle
req_write  in  NUM_REQ  1=write, 0=read
req_phyad  in  5*NUM_REQ  PHY address, slice i = [5i+:5]
req_regad  in  5*NUM_REQ  register address
req_wdata  in  16*NUM_REQ  write data
resp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
resp_rdata  out  16  read data, valid with any resp_valid bit
resp_err  out  1  read got no PHY response (TA bit 2 sampled '1'); valid with resp_valid
busy  out  1  a transaction is in flight
phy_mdc  out  1  MDC
phy_mdio_o  out  1  MDIO output data
phy_mdio_t  out  1  MDIO tristate enable, 1 = released
phy_mdio_i  in  1  MDIO input (pad-synchronised externally)

Behaviour:
- Reset values (asynchronous, immediate):
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - phy_mdc=0, phy_mdio_o=1, phy_mdio_t=1.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts the frame and produces no response. The PHY recovers on the next preamble.
- MDC generator:
  - A counter of 0..MDC_DIV-1 toggles phy_mdc at wrap. It runs only outside IDLE, and MDC is held 0 in IDLE.
  - fall strobe = cycle where phy_mdc goes 1->0; rise strobe = cycle where it goes 0->1.
  - The first MDC period starts with a rise one half-period after the start of PREAMBLE.
- Bit timing:
  - phy_mdio_o/t update on the cycle after a fall strobe; the first bit is driven on entry to PREAMBLE.
  - phy_mdio_i is sampled on the rise strobe.
- FSM:
  - IDLE: if any req_valid, grant the lowest index i after last (wrapping). Pulse req_ready[i], latch payload, set last=i, busy=1, go to PREAMBLE.
  - PREAMBLE: drive '1' (t=0) for PREAMBLE_LEN bits.
  - HEADER: drive 14 bits, MSB first:
    - ST=01
    - OP=10 for read, 01 for write
    - PHYAD[4:0]
    - REGAD[4:0]
  - TA:
    - Write: drive 1 then 0.
    - Read: release (t=1) for both bits. Sample the second TA bit; '1' sets the err flag.
  - DATA:
    - Write: drive wdata[15:0] MSB first.
    - Read: released; shift in 16 bits on rise strobes, MSB first.
  - IDLE_BIT: release the bus for one full MDC period.
  - DONE: pulse resp_valid[i] for one cycle with resp_rdata (0 for writes) and resp_err (0 for writes), then clear busy and return to IDLE.
- Latency:
  - Grant is one cycle after req_valid is seen in IDLE.
  - resp_valid follows (PREAMBLE_LEN+33) MDC periods later (32 frame bits plus the idle bit), i.e. 130*MDC_DIV cycles ±2.
- Next grant: the earliest grant for the next transaction is the cycle after DONE, with no bus gap beyond IDLE_BIT.
- Requester rules:
  - A requester keeps req_valid high until req_ready. Dropping it earlier withdraws the request without side effects.
  - After req_ready, inputs may change freely.
  - A req_valid held after req_ready is a new transaction.
- Round-robin arbitration gives every continuously requesting index a grant within NUM_REQ transactions.

Optional Feature:
- Macro: NTPS_MDIO_PREAMBLE_SUPPRESS_EN.
- Defined:
  - Adds input port preamble_suppress (1 bit), sampled at grant.
  - If it is 1, PREAMBLE is skipped (HEADER follows grant directly) and latency drops by PREAMBLE_LEN MDC periods.
- Undefined: the port is absent and the preamble is always sent.

Decomposition:
- Package ntps_mdio_pkg holds:
  - FSM state encoding: IDLE, PREAMBLE, HEADER, TA, DATA, IDLE_BIT, DONE.
  - Constants MDIO_ST=2'b01, MDIO_OP_RD=2'b10, MDIO_OP_WR=2'b01, MDIO_TA_WR=2'b10, MDIO_HDR_BITS=14, MDIO_DATA_BITS=16.
- One sub-module, ntps_mdio_mdc_gen: divider producing phy_mdc plus rise/fall strobes, with an enable input.
- Arbiter, FSM and shift registers stay in the top.

Test Plan (MDC_DIV=2, NUM_REQ=4):
- Write from req 2 (phyad=5'h01, regad=5'h00, wdata=16'h8000):
  - req_ready[2] pulses once.
  - phy_mdio_o shows 32 ones, then 0101 00001 00000 10, then 1000_0000_0000_0000.
  - resp_valid[2] after 260±2 cycles with resp_err=0.
- Read from req 0 with the PHY model driving TA=z0 and data 16'h2152:
  - phy_mdio_t=1 from TA through IDLE_BIT.
  - resp_rdata=16'h2152, resp_err=0.
- Read with no PHY (pull-up, mdio_i=1) -> resp_err=1, resp_rdata=16'hFFFF.
- All 4 req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no index granted twice before the others are served.
- Assert reset mid-DATA of a write:
  - phy_mdio_t=1 and phy_mdc=0 immediately, with no resp_valid.
  - After release, a new request completes normally.
- With NTPS_MDIO_PREAMBLE_SUPPRESS_EN and preamble_suppress=1: a read frame starts directly with 01 10, and resp_valid arrives after 132±2 cycles.

Source files
------------

// File: rtl/ntps_mdio_pkg.sv
// Shared types and constants for the NTPS MDIO arbiter.
// Holds the frame FSM encoding, Clause-22 field constants, the latched
// request payload and a helper that assembles the 14-bit frame header.
package ntps_mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    TA,
    DATA,
    IDLE_BIT,
    DONE
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST        = 2'b01;
  localparam logic [1:0] MDIO_OP_RD     = 2'b10;
  localparam logic [1:0] MDIO_OP_WR     = 2'b01;
  localparam logic [1:0] MDIO_TA_WR     = 2'b10;
  localparam int         MDIO_HDR_BITS  = 14;
  localparam int         MDIO_DATA_BITS = 16;

  typedef struct packed {
    logic        write;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_req_t;

  // ST, OP, PHYAD, REGAD in transmit order (bit 13 goes out first)
  function automatic logic [MDIO_HDR_BITS-1:0] mdio_header(input logic       write,
                                                           input logic [4:0] phyad,
                                                           input logic [4:0] regad);
    return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad};
  endfunction

endpackage

// File: rtl/ntps_mdio_mdc_gen.sv
// MDC divider: phy_mdc toggles every MDC_DIV clock cycles while enabled and
// is parked low otherwise. rise/fall flag the cycle whose closing edge moves
// mdc 0->1 / 1->0, so logic registered on them lines up with the MDC edge.
module ntps_mdio_mdc_gen #(
  parameter int MDC_DIV = 25
) (
  input  logic axi_aclk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  localparam int CW = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == CW'(MDC_DIV - 1));
  assign rise = wrap && !mdc;
  assign fall = wrap && mdc;

  // half-period counter; disabling restarts the next frame from a clean low half
  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ntps_mdio_arbiter.sv
// Round-robin arbiter sharing one Clause-22 MDIO bus between NUM_REQ
// requesters; one complete frame per grant, response pulsed back to the
// granted requester.
// Optional: NTPS_MDIO_PREAMBLE_SUPPRESS_EN adds preamble_suppress, which
// skips the 32-bit preamble for the granted frame.
module ntps_mdio_arbiter
  import ntps_mdio_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MDC_DIV      = 25,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic                     axi_aclk,
  input  logic                     reset,
`ifdef NTPS_MDIO_PREAMBLE_SUPPRESS_EN
  input  logic                     preamble_suppress,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][4:0]  req_phyad,
  input  logic [NUM_REQ-1:0][4:0]  req_regad,
  input  logic [NUM_REQ-1:0][15:0] req_wdata,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [15:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     phy_mdc,
  output logic                     phy_mdio_o,
  output logic                     phy_mdio_t,
  input  logic                     phy_mdio_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = 6;

  mdio_state_e              state;
  mdio_req_t                cur;
  logic [IW-1:0]            last;
  logic [IW-1:0]            gnt;
  logic [BW-1:0]            bit_cnt;
  logic [14:0]              tx_sh;     // bits still to send in the current field
  logic [15:0]              rx_sh;
  logic                     rx_err;
  logic                     mdc_en, mdc_rise, mdc_fall;
  logic                     gnt_any;
  logic [IW-1:0]            gnt_idx, idx;
  logic [MDIO_HDR_BITS-1:0] hdr_cur;

  assign mdc_en  = (state != IDLE) && (state != DONE);
  assign hdr_cur = mdio_header(cur.write, cur.phyad, cur.regad);

`ifdef NTPS_MDIO_PREAMBLE_SUPPRESS_EN
  logic [MDIO_HDR_BITS-1:0] hdr_now;
  assign hdr_now = mdio_header(req_write[gnt_idx], req_phyad[gnt_idx], req_regad[gnt_idx]);
`endif

  ntps_mdio_mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc (
    .axi_aclk (axi_aclk),
    .reset    (reset),
    .en       (mdc_en),
    .mdc      (phy_mdc),
    .rise     (mdc_rise),
    .fall     (mdc_fall)
  );

  // round-robin pick: scan last+NUM_REQ down to last+1 so the nearest index wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // frame FSM: fields advance on MDC fall, read data captured on MDC rise
  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      last       <= IW'(NUM_REQ - 1);
      gnt        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_err     <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      phy_mdio_o <= 1'b1;
      phy_mdio_t <= 1'b1;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;

      if (mdc_rise && !cur.write) begin
        if (state == TA && bit_cnt == BW'(1)) rx_err <= phy_mdio_i;
        if (state == DATA) rx_sh <= {rx_sh[14:0], phy_mdio_i};
      end

      case (state)
        IDLE: begin
          if (gnt_any) begin
            req_ready[gnt_idx] <= 1'b1;
            cur        <= '{write: req_write[gnt_idx], phyad: req_phyad[gnt_idx],
                            regad: req_regad[gnt_idx], wdata: req_wdata[gnt_idx]};
            gnt        <= gnt_idx;
            last       <= gnt_idx;
            busy       <= 1'b1;
            bit_cnt    <= '0;
            rx_err     <= 1'b0;
            phy_mdio_t <= 1'b0;
`ifdef NTPS_MDIO_PREAMBLE_SUPPRESS_EN
            if (preamble_suppress) begin
              state      <= HEADER;
              phy_mdio_o <= hdr_now[MDIO_HDR_BITS-1];
              tx_sh      <= {hdr_now[MDIO_HDR_BITS-2:0], 2'b00};
            end else begin
              state      <= PREAMBLE;
              phy_mdio_o <= 1'b1;
            end
`else
            state      <= PREAMBLE;
            phy_mdio_o <= 1'b1;
`endif
          end
        end

        PREAMBLE: begin
          if (mdc_fall) begin
            if (bit_cnt == BW'(PREAMBLE_LEN - 1)) begin
              state      <= HEADER;
              bit_cnt    <= '0;
              phy_mdio_o <= hdr_cur[MDIO_HDR_BITS-1];
              tx_sh      <= {hdr_cur[MDIO_HDR_BITS-2:0], 2'b00};
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        HEADER: begin
          if (mdc_fall) begin
            if (bit_cnt == BW'(MDIO_HDR_BITS - 1)) begin
              state      <= TA;
              bit_cnt    <= '0;
              tx_sh      <= {MDIO_TA_WR[0], 14'b0};
              phy_mdio_o <= cur.write ? MDIO_TA_WR[1] : 1'b1;
              phy_mdio_t <= !cur.write;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              tx_sh      <= {tx_sh[13:0], 1'b0};
              phy_mdio_o <= tx_sh[14];
            end
          end
        end

        TA: begin
          if (mdc_fall) begin
            if (bit_cnt == BW'(1)) begin
              state      <= DATA;
              bit_cnt    <= '0;
              tx_sh      <= cur.wdata[14:0];
              phy_mdio_o <= cur.write ? cur.wdata[15] : 1'b1;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              tx_sh      <= {tx_sh[13:0], 1'b0};
              phy_mdio_o <= cur.write ? tx_sh[14] : 1'b1;
            end
          end
        end

        DATA: begin
          if (mdc_fall) begin
            if (bit_cnt == BW'(MDIO_DATA_BITS - 1)) begin
              state      <= IDLE_BIT;
              bit_cnt    <= '0;
              phy_mdio_o <= 1'b1;
              phy_mdio_t <= 1'b1;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              tx_sh      <= {tx_sh[13:0], 1'b0};
              phy_mdio_o <= cur.write ? tx_sh[14] : 1'b1;
            end
          end
        end

        IDLE_BIT: begin
          if (mdc_fall) begin
            state           <= DONE;
            resp_valid[gnt] <= 1'b1;
            resp_rdata      <= cur.write ? 16'h0000 : rx_sh;
            resp_err        <= cur.write ? 1'b0 : rx_err;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
